// File: rtl/framebuffer_scanner_pkg.sv
// Shared SRAM handshake types and the scanner state encoding used by the
// framebuffer read-back path.
package framebuffer_scanner_pkg;

  typedef logic [19:0] SramAddress_t;
  typedef logic [15:0] SramData_t;

  typedef struct packed {
    logic         den;
    logic         oe_n;
    logic         we_n;
    SramAddress_t address;
    SramData_t    dout;
  } SramRequest_t;

  typedef struct packed {
    logic      done;
    SramData_t din;
  } SramResult_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } FramebufferScannerState_t;

endpackage

// File: rtl/framebuffer_scanner_fifo.sv
// Small synchronous pixel FIFO between the SRAM fetch engine and the VGA drain.
// The head and status outputs depend only on registers; flush wins over push/pop.
module pixel_fifo
  import framebuffer_scanner_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  SramData_t                    pushData,
  input  logic                         pop,
  input  logic                         flush,
  output SramData_t                    head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  SramData_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && ((count < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pushData;
  end

endmodule

// File: rtl/framebuffer_scanner.sv
// Streams one frame of pixels out of SRAM, one read per pixel, into a FIFO
// drained by the VGA timing block.
module framebuffer_scanner
  import framebuffer_scanner_pkg::*;
#(
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frameStart,
  input  SramAddress_t baseAddress,
  input  SramResult_t  ramResult,
  output SramRequest_t ramRequest,
  input  logic         pixelReq,
  output SramData_t    pixel,
  output logic         pixelValid,
  output logic         underflow
);

  localparam int TOTAL = H_PIXELS * V_PIXELS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  FramebufferScannerState_t state;
  logic [IDX_W-1:0]         idx;
  SramAddress_t             base;
  SramAddress_t             address;
  logic                     den;
  logic                     oe_n;
  logic                     pending;

  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic                     restart_on_done;

  // The controller cannot abort an access, so a restart requested in ISSUE
  // takes effect only when the in-flight read completes.
  assign restart_on_done = (state == ISSUE) && ramResult.done && (pending || frameStart);
  assign flush           = (frameStart && (state != ISSUE)) || restart_on_done;
  assign push            = (state == ISSUE) && ramResult.done && !pending && !frameStart;
  assign pop             = pixelReq && !fifo_empty;
  assign pixelValid      = !fifo_empty;

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData (ramResult.din),
    .pop      (pop),
    .flush    (flush),
    .head     (pixel),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    ramRequest         = '0;
    ramRequest.den     = den;
    ramRequest.oe_n    = oe_n;
    ramRequest.we_n    = 1'b1;
    ramRequest.address = address;
    ramRequest.dout    = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      base    <= '0;
      address <= '0;
      den     <= 1'b0;
      oe_n    <= 1'b1;
      pending <= 1'b0;
    end else begin
      if (frameStart) base <= baseAddress;
      case (state)
        ISSUE: begin
          if (frameStart) pending <= 1'b1;
          if (ramResult.done) begin
            den   <= 1'b0;
            oe_n  <= 1'b1;
            state <= GAP;
            if (pending || frameStart) begin
              // Restart lands in GAP so the controller still sees an idle cycle.
              idx     <= '0;
              pending <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          if (frameStart) begin
            state   <= ISSUE;
            idx     <= '0;
            address <= baseAddress;
            den     <= 1'b1;
            oe_n    <= 1'b0;
            pending <= 1'b0;
          end else if (state == GAP) begin
            if (idx == IDX_W'(TOTAL)) begin
              state <= DONE;
            end else if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
              state   <= ISSUE;
              den     <= 1'b1;
              oe_n    <= 1'b0;
              address <= base + SramAddress_t'(idx);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (frameStart) begin
      underflow <= 1'b0;
    end else if (pixelReq && fifo_empty && !flush) begin
      underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Scoreboard bench for framebuffer_scanner: an SRAM controller model answers
// reads while a frame-level model predicts the address stream and pixel order.
module tb_framebuffer_scanner;
  import framebuffer_scanner_pkg::*;

  localparam int H     = 4;
  localparam int V     = 8;
  localparam int TOTAL = H * V;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frameStart = 1'b0;
  logic         pixelReq = 1'b0;
  SramAddress_t baseAddress = '0;
  SramResult_t  ramResult = '0;
  SramRequest_t ramRequest;
  SramData_t    pixel;
  logic         pixelValid;
  logic         underflow;

  int           checks = 0;
  int           errors = 0;
  int           lat = 2;
  bit           rand_lat = 1'b0;
  bit           busy = 1'b0;
  int           req_count = 0;
  SramAddress_t addr_log[$];
  SramAddress_t addr_q[$];
  SramData_t    exp_q[$];
  SramAddress_t cur_exp = '0;
  bit           model_uf = 1'b0;
  bit           pending = 1'b0;
  SramAddress_t pend_base = '0;

  always #5 clk = ~clk;

  framebuffer_scanner #(
    .H_PIXELS   (H),
    .V_PIXELS   (V),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frameStart  (frameStart),
    .baseAddress (baseAddress),
    .ramResult   (ramResult),
    .ramRequest  (ramRequest),
    .pixelReq    (pixelReq),
    .pixel       (pixel),
    .pixelValid  (pixelValid),
    .underflow   (underflow)
  );

  function automatic SramData_t sram_word(SramAddress_t a);
    logic [19:0] t;
    t = a * 20'd7 + 20'd3;
    return t[15:0] ^ 16'hA5C3;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic start_frame(SramAddress_t b);
    addr_q.delete();
    for (int i = 0; i < TOTAL; i++) addr_q.push_back(b + SramAddress_t'(i));
  endtask

  task automatic pulse_frame(SramAddress_t b, bit check_first);
    @(negedge clk);
    frameStart  = 1'b1;
    baseAddress = b;
    @(negedge clk);
    frameStart = 1'b0;
    if (check_first) begin
      #1;
      check_output("first_request_den", ramRequest.den, 1'b1);
      check_output("first_request_address", ramRequest.address, b);
    end
  endtask

  task automatic wait_requests(int n, int budget, string name);
    for (int i = 0; i < budget && req_count < n; i++) begin
      @(negedge clk);
      #2;
    end
    if (req_count < n) timeout_fail(name);
  endtask

  // SRAM controller: accepts a read, answers after a latency, then
  // insists on a deasserted cycle before the next access.
  initial begin : sram_model
    int           cnt;
    SramAddress_t held;
    cnt  = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ramResult.done = 1'b0;
        busy = 1'b0;
        cnt  = 0;
      end else if (ramResult.done) begin
        ramResult.done = 1'b0;
        busy = 1'b0;
        check_output("gap_den_low", ramRequest.den, 1'b0);
      end else if (busy) begin
        check_output("held_request", {ramRequest.den, ramRequest.oe_n, ramRequest.address},
                     {1'b1, 1'b0, held});
        cnt--;
        if (cnt <= 0) begin
          ramResult.done = 1'b1;
          ramResult.din  = sram_word(held);
        end
      end else if (ramRequest.den) begin
        held = ramRequest.address;
        addr_log.push_back(held);
        req_count++;
        busy = 1'b1;
        check_output("read_strobes", {ramRequest.oe_n, ramRequest.we_n, ramRequest.dout},
                     {1'b0, 1'b1, 16'h0});
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_request: got address 0x%0h, expected no request at %0t",
                   held, $time);
          cur_exp = held;
        end else begin
          cur_exp = addr_q.pop_front();
          check_output("request_address", held, cur_exp);
        end
        cnt = rand_lat ? int'($urandom_range(3, 1)) : lat;
      end
    end
  end

  // Frame-level model: frame k delivers mem[base + k] in order; a restart
  // empties the buffer, and reads completing under a pending restart are dropped.
  initial begin : scoreboard
    bit flush;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        model_uf = 1'b0;
        pending  = 1'b0;
      end else begin
        check_output("pixel_valid", pixelValid, exp_q.size() > 0);
        check_output("pixel_head", pixel, (exp_q.size() > 0) ? exp_q[0] : 16'h0);
        check_output("underflow", underflow, model_uf);
        flush = (frameStart && !busy) || (ramResult.done && (pending || frameStart));
        if (frameStart) model_uf = 1'b0;
        if (flush) begin
          exp_q.delete();
          start_frame(frameStart ? baseAddress : pend_base);
          pending = 1'b0;
        end else begin
          if (frameStart) begin
            pending   = 1'b1;
            pend_base = baseAddress;
          end
          if (pixelReq) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else if (!frameStart) model_uf = 1'b1;
          end
          if (ramResult.done) exp_q.push_back(sram_word(cur_exp));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int li;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_den", ramRequest.den, 1'b0);
    check_output("reset_oe_n", ramRequest.oe_n, 1'b1);
    check_output("reset_we_n", ramRequest.we_n, 1'b1);
    check_output("reset_address", ramRequest.address, 20'h0);
    check_output("reset_dout", ramRequest.dout, 16'h0);
    check_output("reset_pixel", pixel, 16'h0);
    check_output("reset_pixel_valid", pixelValid, 1'b0);
    check_output("reset_underflow", underflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic fetch");
    lat = 2;
    pulse_frame(20'h01000, 1'b1);
    wait_requests(16, 400, "fill_fifo");
    repeat (20) @(negedge clk);
    #1;
    check_output("no_17th_request", req_count, 16);
    check_output("den_low_when_full", ramRequest.den, 1'b0);
    check_output("full_head", pixel, sram_word(20'h01000));

    $display("[TB] drain");
    @(negedge clk);
    pixelReq = 1'b1;
    repeat (16) @(negedge clk);
    pixelReq = 1'b0;
    wait_requests(17, 100, "resume_fetch");
    check_output("resume_address", addr_log[16], 20'h01010);
    repeat (250) begin
      @(negedge clk);
      pixelReq = 1'($urandom_range(1, 0));
    end
    pixelReq = 1'b1;
    repeat (40) @(negedge clk);
    pixelReq = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_output("frame_end_count", req_count, TOTAL);
    check_output("idle_after_frame", ramRequest.den, 1'b0);

    $display("[TB] underflow and mid-access restart");
    lat = 3;
    pulse_frame(20'h03000, 1'b0);
    pixelReq = 1'b1;
    @(negedge clk);
    pixelReq = 1'b0;
    #1;
    check_output("underflow_set", underflow, 1'b1);
    check_output("underflow_pixel", pixel, 16'h0);
    check_output("underflow_no_pop", pixelValid, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (addr_q.size() == TOTAL - 6 && busy) break;
    end
    if (!(addr_q.size() == TOTAL - 6 && busy)) timeout_fail("reach_idx5");
    frameStart  = 1'b1;
    baseAddress = 20'h02000;
    li = req_count;
    @(negedge clk);
    #2;
    frameStart = 1'b0;
    #1;
    check_output("underflow_cleared", underflow, 1'b0);
    for (int i = 0; i < 20 && !ramResult.done; i++) begin
      @(negedge clk);
      #1;
    end
    if (!ramResult.done) timeout_fail("restart_done");
    @(negedge clk);
    #1;
    check_output("restart_flushed", pixelValid, 1'b0);
    check_output("restart_gap_den", ramRequest.den, 1'b0);
    wait_requests(li + 1, 50, "restart_request");
    check_output("restart_address", addr_log[li], 20'h02000);

    $display("[TB] frame end and address wrap");
    rand_lat = 1'b1;
    @(negedge clk);
    frameStart  = 1'b1;
    baseAddress = 20'hFFFFC;
    #2;
    li = req_count;
    @(negedge clk);
    frameStart = 1'b0;
    repeat (300) begin
      @(negedge clk);
      pixelReq = 1'($urandom_range(1, 0));
    end
    pixelReq = 1'b1;
    repeat (40) @(negedge clk);
    pixelReq = 1'b0;
    #1;
    check_output("wrap_read_count", req_count - li, TOTAL);
    if (addr_log.size() > li + 4) begin
      check_output("wrap_last_address", addr_log[li + 3], 20'hFFFFF);
      check_output("wrap_through_zero", addr_log[li + 4], 20'h00000);
    end else begin
      timeout_fail("wrap_log");
    end
    repeat (15) @(negedge clk);
    #1;
    check_output("no_request_after_done", req_count - li, TOTAL);
    check_output("done_den_low", ramRequest.den, 1'b0);

    $display("[TB] async reset mid-access");
    rand_lat = 1'b0;
    lat = 2;
    pulse_frame(20'h04000, 1'b0);
    li = req_count + 3;
    wait_requests(li, 100, "pre_reset_fetch");
    #1;
    check_output("pre_reset_valid", pixelValid, 1'b1);
    rst = 1'b1;
    #1;
    check_output("async_den", ramRequest.den, 1'b0);
    check_output("async_oe_n", ramRequest.oe_n, 1'b1);
    check_output("async_address", ramRequest.address, 20'h0);
    check_output("async_pixel", pixel, 16'h0);
    check_output("async_pixel_valid", pixelValid, 1'b0);
    check_output("async_underflow", underflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulse_frame(20'h05000, 1'b1);
    repeat (60) begin
      @(negedge clk);
      pixelReq = 1'($urandom_range(1, 0));
    end
    pixelReq = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanner.md
# framebuffer_scanner

Reads the pixel framebuffer back out of SRAM for display: the read-side counterpart to the glyph renderers that write pixels into the same SRAM region. On each frame start it latches the framebuffer base address. It fetches pixels linearly, one SRAM read per pixel, through the shared `SramRequest_t`/`SramResult_t` handshake, and buffers them in a small FIFO. The VGA timing block drains that FIFO one pixel per `pixelReq`.

## Interface
Parameters:
- `H_PIXELS`, default 640: active pixels per line (`CONSOLE_COLUMNS * WIDTH_PER_CHARACTER`).
- `V_PIXELS`, default 480: active lines per frame.
- `FIFO_DEPTH`, default 16: pixel FIFO entries; must be a power of two and at least 4.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  system clock; single domain.
- `rst`  in  1  async active-high reset.
- `frameStart`  in  1  one-cycle pulse from VGA timing at start of vertical blank.
- `baseAddress`  in  `SramAddress_t`  framebuffer base; sampled only on `frameStart`.
- `ramResult`  in  `SramResult_t`  controller response; `done` is a 1-cycle completion strobe, `din` is read data valid with `done`.
- `ramRequest`  out  `SramRequest_t`  `den`, `oe_n`, `we_n`, `address`, `dout`.
- `pixelReq`  in  1  VGA consumes the head pixel this cycle.
- `pixel`  out  `SramData_t`  FIFO head; 0 when empty.
- `pixelValid`  out  1  FIFO non-empty.
- `underflow`  out  1  sticky: `pixelReq` arrived while FIFO was empty; cleared by `frameStart`.

## Operation
- Read-only master:
  - `we_n` is constantly 1 and `dout` is constantly 0.
  - A read is `den`=1 with `oe_n`=0, held with a stable `address` until `ramResult.done`.
- Pixel index `idx` counts 0 to `H_PIXELS*V_PIXELS-1`.
  - Address = latched base + `idx`, truncated to the `SramAddress_t` width (wraps silently).
- States:
  - IDLE:
    - Nothing issued.
    - On `frameStart`: latch base, set `idx`=0, flush FIFO, clear `underflow`, go to ISSUE.
  - ISSUE:
    - Request asserted.
    - On `done`: push `din` into FIFO, increment `idx`, go to GAP.
    - If a restart is pending, the word is discarded instead of pushed, and the restart is then performed as from IDLE.
  - GAP:
    - `den`=0, `oe_n`=1 for at least one cycle; the controller requires a deasserted cycle between accesses.
    - Go to DONE if `idx` == total.
    - Go to ISSUE if FIFO count < `FIFO_DEPTH`.
    - Otherwise stay in GAP (back-pressure).
  - DONE:
    - Idle until `frameStart`, then restart.
- `frameStart` handling:
  - Seen in IDLE, GAP or DONE: restart immediately.
  - Seen in ISSUE: set a pending-restart flag. The in-flight access must complete because the controller cannot be aborted. The restart happens on that `done`.
- FIFO:
  - Push only from ISSUE on `done`. ISSUE is entered only when count < `FIFO_DEPTH`, and count cannot rise while in ISSUE, so overflow is impossible.
  - Pop when `pixelReq` && `pixelValid`.
  - Push and pop in the same cycle leave count unchanged.
  - `pixelReq` while empty: no pop, `pixel` stays 0, `underflow` set.
- Flush on restart empties the FIFO in the same cycle. A simultaneous `pixelReq` is ignored and does not set `underflow`.

## Timing
- Reset values:
  - state IDLE; `idx` 0; FIFO empty.
  - `den` 0, `oe_n` 1, `we_n` 1, `address` 0, `dout` 0.
  - `pixel` 0, `pixelValid` 0, `underflow` 0.
- `frameStart` at cycle N: `den`=1 with `address`=base from cycle N+1.
- `done` at cycle D: `pixelValid`=1 and `pixel`=`din` at D+1 if the FIFO was empty; `den` low at D+1; next request no earlier than D+2.
- Peak throughput is one pixel per (controller latency + 2) cycles. The controller must be fast enough that the FIFO does not run dry during active video. Verification reports `underflow` but does not fix the rate.
- `pixel`/`pixelValid` are registered FIFO outputs; there is no combinational path from `pixelReq` to `pixel`.
- `rst` mid-frame: everything returns to reset values immediately, and any in-flight SRAM access is abandoned.

## Structure
- Shared package `DataType.svh`:
  - reuse `SramRequest_t`, `SramResult_t`, `SramData_t`, `SramAddress_t`;
  - add `FramebufferScannerState_t` (IDLE, ISSUE, GAP, DONE).
- Sub-module `pixel_fifo`: synchronous FIFO with parameter `DEPTH` and ports `push`, `pushData`, `pop`, `flush`, `head`, `empty`, `count`. `flush` has priority over push/pop.
- Top level holds the FSM, the `idx` counter, the latched base and the pending-restart flag.

## Test plan
- Basic fetch:
  - Stimulus: base=0x1000, controller `done` 2 cycles after request, `pixelReq` tied low.
  - Required: addresses 0x1000..0x100F issued; FIFO full at 16; `den` stays low in GAP; no 17th request.
- Drain:
  - Stimulus: from the full-FIFO state, pulse `pixelReq` each cycle for 16 cycles.
  - Required: `pixel` sequence matches SRAM model contents at 0x1000..0x100F; fetching resumes at 0x1010.
- Underflow:
  - Stimulus: `pixelReq` high one cycle after `frameStart`.
  - Required: `underflow`=1, `pixel`=0, no pop; the next `frameStart` clears `underflow`.
- Mid-access restart:
  - Stimulus: `frameStart` with new base 0x2000 during ISSUE at `idx`=5; `done` 3 cycles later.
  - Required: old word not pushed; FIFO empty; next request address 0x2000.
- Frame end and wrap:
  - Stimulus: `H_PIXELS`=4, `V_PIXELS`=2, base = max address − 3.
  - Required: 8 reads whose addresses wrap through 0; state DONE; no further requests until `frameStart`.
- Async reset:
  - Stimulus: assert `rst` mid-ISSUE.
  - Required: all outputs at reset values in the same cycle.
